// File: rtl/mem_cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through cache.
package mem_cache_pkg;

    localparam int DEF_LINES  = 16;
    localparam int DEF_ADDR_W = 32;
    localparam int IDX_W      = $clog2(DEF_LINES);
    localparam int TAG_W      = DEF_ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE,
        RESP
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } line_t;

endpackage

// File: rtl/mem_cache_store.sv
// Tag/valid/data arrays for the cache: asynchronous read, one synchronous write port,
// valid bits cleared by async reset or by a flush pulse.
module mem_cache_store #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents survive reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between the core port and a
// request/ack backing memory.
module mem_cache
    import mem_cache_pkg::*;
#(
    parameter int LINES  = DEF_LINES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [31:0]       cpu_wd,
    output logic [31:0]       cpu_rd,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    input  logic              mem_ack
);

    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - 2 - IW;

    state_e              state_q, state_d;
    logic [ADDR_W-3:0]   adr_q, adr_d;
    logic                we_q, we_d;
    logic [31:0]         wd_q, wd_d;
    logic [31:0]         rd_q, rd_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
    logic [31:0]         mem_wd_q, mem_wd_d;

    logic [IW-1:0]       idx;
    logic [TW-1:0]       tag;
    logic                line_valid;
    logic [TW-1:0]       line_tag;
    logic [31:0]         line_data;
    logic                hit;
    logic                wr_en;
    logic [31:0]         wr_data;
    logic                flush_clr;
    logic                adr_lsb_unused;

    // Byte offset is dropped; only the word address is kept.
    assign adr_lsb_unused = ^cpu_adr[1:0];

    assign idx = adr_q[IW-1:0];
    assign tag = adr_q[ADDR_W-3:IW];
    assign hit = line_valid && (line_tag == tag);

    mem_cache_store #(
        .LINES (LINES),
        .IDX_W (IW),
        .TAG_W (TW)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_clr),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wd_d      = wd_q;
        rd_d      = rd_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        mem_adr_d = mem_adr_q;
        mem_wd_d  = mem_wd_q;
        wr_en     = 1'b0;
        wr_data   = mem_rd;
        flush_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    flush_clr = 1'b1;
                end else if (cpu_req) begin
                    adr_d   = cpu_adr[ADDR_W-1:2];
                    we_d    = cpu_we;
                    wd_d    = cpu_wd;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    mem_adr_d = {adr_q, 2'b00};
                    mem_wd_d  = wd_q;
                    state_d   = WRITE;
                end else if (hit) begin
                    rd_d    = line_data;
                    state_d = RESP;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    mem_adr_d = {adr_q, 2'b00};
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    wr_en     = 1'b1;
                    wr_data   = mem_rd;
                    rd_d      = mem_rd;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            // The line cannot change while waiting, so the hit is re-evaluated here.
            WRITE: begin
                if (mem_ack) begin
                    if (hit) begin
                        wr_en   = 1'b1;
                        wr_data = wd_q;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            wd_q      <= '0;
            rd_q      <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_wd_q  <= mem_wd_d;
        end
    end

    assign cpu_rd    = rd_q;
    assign cpu_ready = (state_q == RESP);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_mem_cache.sv
// Directed scoreboard bench for mem_cache: a backing-memory responder with programmable
// ack delay, and expected results queued at drive time and popped at cpu_ready.
module tb_mem_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ack;

    int   tests = 0;
    int   fails = 0;
    int   ack_delay = 1;
    logic hold_ack = 1'b0;
    logic force_ack = 1'b0;

    typedef struct {
        logic        is_read;
        logic [31:0] rd;
        int          lat;
        logic        use_mem;
        logic        mem_we;
        logic [31:0] mem_adr;
        logic [31:0] mem_wd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_cache dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory: acks in the ack_delay-th cycle that mem_req is seen high.
    initial begin : responder
        logic [31:0] backing [logic [31:0]];
        int cnt;
        cnt = 0;
        backing[32'h40]  = 32'hDEADBEEF;
        backing[32'h440] = 32'h44044044;
        mem_ack = 1'b0;
        mem_rd  = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack = 1'b1;
                mem_rd  = 32'hBAD0BAD0;
            end else if (mem_req === 1'b1 && !hold_ack) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                    if (mem_we) begin
                        backing[mem_adr] = mem_wd;
                    end else begin
                        mem_rd = backing.exists(mem_adr) ? backing[mem_adr] : 32'h0;
                    end
                end
            end else if (mem_req !== 1'b1) begin
                cnt = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                                  input int delay, input logic pre_flush,
                                  input logic [31:0] exp_rd, input int exp_lat, input logic exp_mem);
        exp_t e;
        exp_t got;
        int   lat;
        logic mem_seen;
        logic done;
        e.is_read = !we;
        e.rd      = exp_rd;
        e.lat     = exp_lat;
        e.use_mem = exp_mem;
        e.mem_we  = we;
        e.mem_adr = {adr[31:2], 2'b00};
        e.mem_wd  = wd;
        sb.push_back(e);
        ack_delay = delay;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_adr  = adr;
        cpu_wd   = wd;
        flush    = pre_flush;
        lat      = 0;
        mem_seen = 1'b0;
        done     = 1'b0;
        while (!done && lat < 50) begin
            @(negedge clk);
            if (mem_req === 1'b1 && !mem_seen) begin
                mem_seen = 1'b1;
                check_output("mem_we", {31'b0, mem_we}, {31'b0, sb[0].mem_we});
                check_output("mem_adr", mem_adr, sb[0].mem_adr);
                if (sb[0].mem_we) check_output("mem_wd", mem_wd, sb[0].mem_wd);
            end
            if (cpu_ready === 1'b1) begin
                done    = 1'b1;
                cpu_req = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                flush = 1'b0;
                lat++;
            end
        end
        cpu_req = 1'b0;
        flush   = 1'b0;
        got = sb.pop_front();
        check_output("ready_seen", {31'b0, done}, 32'd1);
        if (done) begin
            check_output("latency", lat, got.lat);
            check_output("mem_used", {31'b0, mem_seen}, {31'b0, got.use_mem});
            if (got.is_read) check_output("cpu_rd", cpu_rd, got.rd);
            @(negedge clk);
            check_output("ready_pulse", {31'b0, cpu_ready}, 32'd0);
        end
    endtask

    initial begin : main
        logic seen;
        reset   = 1'b0;
        flush   = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        cpu_adr = '0;
        cpu_wd  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        check_output("rst_cpu_rd", cpu_rd, 32'd0);
        check_output("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_output("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check_output("rst_mem_adr", mem_adr, 32'd0);
        check_output("rst_mem_wd", mem_wd, 32'd0);
        reset = 1'b1;

        apply_stimulus(1'b0, 32'h40, 32'h0, 3, 1'b0, 32'hDEADBEEF, 5, 1'b1);
        apply_stimulus(1'b0, 32'h40, 32'h0, 3, 1'b0, 32'hDEADBEEF, 2, 1'b0);
        apply_stimulus(1'b1, 32'h40, 32'h12345678, 2, 1'b0, 32'h0, 4, 1'b1);
        apply_stimulus(1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h12345678, 2, 1'b0);
        apply_stimulus(1'b1, 32'h80, 32'hCAFEF00D, 1, 1'b0, 32'h0, 3, 1'b1);
        apply_stimulus(1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h12345678, 2, 1'b0);
        apply_stimulus(1'b0, 32'h440, 32'h0, 2, 1'b0, 32'h44044044, 4, 1'b1);
        apply_stimulus(1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h12345678, 4, 1'b1);
        apply_stimulus(1'b0, 32'h43, 32'h0, 2, 1'b0, 32'h12345678, 2, 1'b0);

        // Flush raised together with a request: the request waits one cycle, then misses.
        apply_stimulus(1'b0, 32'h42, 32'h0, 2, 1'b1, 32'h12345678, 5, 1'b1);

        hold_ack = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 32'h440;
        seen    = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen = 1'b1;
        end
        check_output("fill_reached", {31'b0, seen}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        check_output("midrst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        cpu_req  = 1'b0;
        hold_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        force_ack = 1'b1;
        @(posedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("late_ack_ready", {31'b0, cpu_ready}, 32'd0);
            check_output("late_ack_req", {31'b0, mem_req}, 32'd0);
        end

        apply_stimulus(1'b0, 32'h440, 32'h0, 2, 1'b0, 32'h44044044, 4, 1'b1);
        apply_stimulus(1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h12345678, 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
